// File: rtl/prgrom_loader.sv
// prgrom_loader: receives a framed program image byte by byte, assembles
// big-endian 32-bit words and writes them to the instruction ROM. The fetch
// unit is held in reset (cpu_hold) while a load is in progress.
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes, MSB first, and an
// XOR checksum byte when PRGROM_LOADER_CHECKSUM_EN is defined.
// ADDR_WIDTH must be at most 16 because word_count is 16 bits wide.
module prgrom_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_load,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_err,
   output logic [15:0]           word_count
);

`ifdef PRGROM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
   } state_t;
`endif

   // Largest accepted word count: the full memory capacity.
   localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

   state_t                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [23:0]             word_q, word_d;   // first three bytes of the word
   logic [1:0]              idx_q, idx_d;
   logic [15:0]             wcnt_q, wcnt_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    err_q, err_d;
`ifdef PRGROM_LOADER_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
`endif

   logic [16:0]             len_full;
   logic                    last_word;

   assign len_full  = {1'b0, len_q[15:8], rx_byte};
   assign last_word = (wcnt_q == len_q - 16'd1);

   // Next-state and datapath: byte framing, word assembly, write issue.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      word_d  = word_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
`ifdef PRGROM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_load) begin
               state_d = S_LEN_HI;
               err_d   = 1'b0;
               wcnt_d  = 16'd0;
               idx_d   = 2'd0;
               word_d  = 24'd0;
`ifdef PRGROM_LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               len_d[15:8] = rx_byte;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (rx_valid) begin
               len_d[7:0] = rx_byte;
               if (len_full == 17'd0)     state_d = S_DONE;
               else if (len_full > CAP)   state_d = S_ERR;
               else                       state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               word_d = {word_q[15:0], rx_byte};
               idx_d  = idx_q + 2'd1;
`ifdef PRGROM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_byte;
`endif
               if (idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                  wdata_d = {word_q, rx_byte};
                  wcnt_d  = wcnt_q + 16'd1;
`ifdef PRGROM_LOADER_CHECKSUM_EN
                  if (last_word) state_d = S_CSUM;
`else
                  if (last_word) state_d = S_DONE;
`endif
               end
            end
         end
`ifdef PRGROM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: state_d = S_IDLE;
         S_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; a partial word is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         word_q  <= 24'd0;
         idx_q   <= 2'd0;
         wcnt_q  <= 16'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
`ifdef PRGROM_LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
`ifdef PRGROM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = (state_q != S_IDLE);
   assign load_done  = (state_q == S_DONE);
   assign load_err   = err_q;
   assign word_count = wcnt_q;

endmodule

// File: tb/tb_prgrom_loader.sv
// Directed bench for prgrom_loader (ADDR_WIDTH = 14). Works with or without
// PRGROM_LOADER_CHECKSUM_EN; checksum bytes are sent only when it is defined.
module tb_prgrom_loader;
   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          reset, start_load, rx_valid;
   logic [7:0]    rx_byte;
   logic          mem_we, cpu_hold, load_done, load_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [15:0]   word_count;

   int n_chk = 0;
   int n_fail = 0;

   // write log and protocol observations, sampled on the falling edge
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          done_cnt = 0;
   int          hold_viol = 0;
   int          dbl_we = 0;
   logic        we_prev = 1'b0;

   prgrom_loader #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start_load(start_load),
      .rx_valid(rx_valid), .rx_byte(rx_byte),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
      .word_count(word_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mem_we) begin
         wr_addr.push_back(32'(mem_addr));
         wr_data.push_back(mem_wdata);
         if (!cpu_hold) hold_viol++;
         if (we_prev)   dbl_we++;
      end
      we_prev = mem_we;
      if (load_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt  = 0;
      hold_viol = 0;
      dbl_we    = 0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clock);
      rx_valid = 1'b0;
      idle(gap);
   endtask

   task automatic start();
      start_load = 1'b1;
      @(negedge clock);
      start_load = 1'b0;
   endtask

   task automatic check_basic(input string tag);
      chk({tag, " nwr"},   32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         chk({tag, " a0"}, wr_addr[0], 32'd0);
         chk({tag, " d0"}, wr_data[0], 32'h12345678);
         chk({tag, " a1"}, wr_addr[1], 32'd1);
         chk({tag, " d1"}, wr_data[1], 32'h9ABCDEF0);
      end
      chk({tag, " done"},  32'(done_cnt), 32'd1);
      chk({tag, " wc"},    32'(word_count), 32'd2);
      chk({tag, " hold"},  32'(cpu_hold), 32'd0);
      chk({tag, " err"},   32'(load_err), 32'd0);
      chk({tag, " wehold"}, 32'(hold_viol), 32'd0);
      chk({tag, " we1cyc"}, 32'(dbl_we), 32'd0);
   endtask

   logic [7:0] basic[10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                             8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
   int gaps[10] = '{3, 0, 5, 1, 2, 4, 0, 3, 1, 5};

   initial begin
      reset = 1'b1; start_load = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
      idle(3);
      reset = 1'b0;
      @(negedge clock);

      // reset state
      chk("rst we",    32'(mem_we), 32'd0);
      chk("rst addr",  32'(mem_addr), 32'd0);
      chk("rst wdata", mem_wdata, 32'd0);
      chk("rst hold",  32'(cpu_hold), 32'd0);
      chk("rst done",  32'(load_done), 32'd0);
      chk("rst err",   32'(load_err), 32'd0);
      chk("rst wc",    32'(word_count), 32'd0);

      // basic back-to-back load
      clear_log();
      start();
      chk("basic hold rise", 32'(cpu_hold), 32'd1);
      foreach (basic[i]) send(basic[i], 0);
`ifdef PRGROM_LOADER_CHECKSUM_EN
      send(8'h00, 0);
`endif
      idle(6);
      check_basic("basic");

      // zero length
      clear_log();
      start();
      send(8'h00, 0); send(8'h00, 0);
      idle(5);
      chk("zero nwr",  32'(wr_addr.size()), 32'd0);
      chk("zero done", 32'(done_cnt), 32'd1);
      chk("zero wc",   32'(word_count), 32'd0);
      chk("zero hold", 32'(cpu_hold), 32'd0);

      // overflow: 0x4001 words exceeds 2^14
      clear_log();
      start();
      send(8'h40, 0); send(8'h01, 0);
      idle(5);
      chk("ovf err",  32'(load_err), 32'd1);
      chk("ovf nwr",  32'(wr_addr.size()), 32'd0);
      chk("ovf done", 32'(done_cnt), 32'd0);
      chk("ovf hold", 32'(cpu_hold), 32'd0);
      start();
      chk("ovf clr err", 32'(load_err), 32'd0);
      send(8'h00, 0); send(8'h00, 0);
      idle(4);
      chk("ovf next done", 32'(done_cnt), 32'd1);

      // exactly full capacity (0x4000) is accepted; abort with reset
      clear_log();
      start();
      send(8'h40, 0); send(8'h00, 0);
      idle(3);
      chk("cap err",  32'(load_err), 32'd0);
      chk("cap hold", 32'(cpu_hold), 32'd1);
      reset = 1'b1; @(negedge clock); reset = 1'b0;
      chk("cap rst hold", 32'(cpu_hold), 32'd0);

`ifdef PRGROM_LOADER_CHECKSUM_EN
      // checksum mismatch then match
      clear_log();
      start();
      send(8'h00, 0); send(8'h01, 0);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      send(8'h45, 0);
      idle(5);
      chk("csum bad nwr", 32'(wr_addr.size()), 32'd1);
      if (wr_data.size() == 1) chk("csum bad d0", wr_data[0], 32'h11223344);
      chk("csum bad err",  32'(load_err), 32'd1);
      chk("csum bad done", 32'(done_cnt), 32'd0);
      clear_log();
      start();
      send(8'h00, 0); send(8'h01, 0);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      send(8'h44, 0);
      idle(5);
      chk("csum ok err",  32'(load_err), 32'd0);
      chk("csum ok done", 32'(done_cnt), 32'd1);
      chk("csum ok wc",   32'(word_count), 32'd1);
`endif

      // reset mid-load discards the partial word; later bytes ignored
      clear_log();
      start();
      send(8'h00, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
      reset = 1'b1; @(negedge clock); reset = 1'b0;
      chk("mrst hold",  32'(cpu_hold), 32'd0);
      chk("mrst wc",    32'(word_count), 32'd0);
      chk("mrst addr",  32'(mem_addr), 32'd0);
      chk("mrst wdata", mem_wdata, 32'd0);
      chk("mrst err",   32'(load_err), 32'd0);
      send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
      send(8'h77, 0); send(8'h88, 0);
      idle(4);
      chk("mrst nwr",   32'(wr_addr.size()), 32'd0);
      chk("mrst done",  32'(done_cnt), 32'd0);
      chk("mrst hold2", 32'(cpu_hold), 32'd0);

      // reset beats a simultaneous start_load
      reset = 1'b1; start_load = 1'b1; @(negedge clock);
      reset = 1'b0; start_load = 1'b0;
      chk("rst+start hold", 32'(cpu_hold), 32'd0);

      // stray bytes in IDLE, then spaced bytes
      clear_log();
      send(8'hA5, 1); send(8'h5A, 0); send(8'hFF, 2);
      start();
      foreach (basic[i]) send(basic[i], gaps[i]);
`ifdef PRGROM_LOADER_CHECKSUM_EN
      send(8'h00, 2);
`endif
      idle(6);
      check_basic("spaced");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prgrom_loader.md
# prgrom_loader

Byte-stream programmer for the CPU's instruction memory. It accepts a framed program image one byte at a time from the serial receive path, assembles big-endian 32-bit words, and issues single-cycle word writes to the instruction ROM's write port. The word addressing matches the fetch unit's addressing, where word address equals PC[15:2]. While a load is in progress it asserts `cpu_hold` so the fetch stage is held in reset until the image is complete.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_load`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid this cycle.
- `rx_byte`  in  8  received byte.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  high in every state except IDLE.
- `load_done`  out  1  one-cycle pulse when the load completes successfully.
- `load_err`  out  1  sticky error flag; cleared by `start_load` or `reset`.
- `word_count`  out  16  number of words written in the current or last load.

## Operation
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then 4·N data bytes with the MSB first in each word. When CHECKSUM is enabled, one checksum byte follows.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
  - IDLE: on `start_load`, go to LEN_HI, clear `load_err`, `word_count`, byte index and checksum.
  - LEN_HI: on `rx_valid`, latch N[15:8], go to LEN_LO.
  - LEN_LO: on `rx_valid`, latch N[7:0], then:
    - N = 0 → DONE.
    - N > 2^ADDR_WIDTH → ERR.
    - otherwise → DATA.
  - DATA: each `rx_valid` shifts the byte into the word register and increments the 2-bit byte index.
    - On the 4th byte, register a write at address `word_count` and increment `word_count`.
    - After word N: go to CSUM if enabled, else DONE.
  - CSUM: on `rx_valid`, compare the byte to the running XOR of all data bytes. Match → DONE; mismatch → ERR.
  - DONE: pulse `load_done`, go to IDLE.
  - ERR: set `load_err`, go to IDLE. Words already written stay in memory.
- `rx_valid` outside LEN_HI, LEN_LO, DATA and CSUM is ignored. `start_load` outside IDLE is ignored.
- The address equals the word index, so `mem_addr` never wraps. Overflow is rejected at LEN_LO.
- `word_count` holds its value after DONE or ERR until the next `start_load`.

## Timing
- Reset values: state IDLE; `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 0, `load_done` 0, `load_err` 0, `word_count` 0.
- `rx_valid` may arrive on consecutive cycles. Every byte is accepted with no backpressure.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. The write appears 1 cycle after the edge that samples the 4th byte and is high for exactly 1 cycle.
- `cpu_hold` rises 1 cycle after `start_load` is sampled and falls in the cycle after DONE or ERR. The final `mem_we` always occurs while `cpu_hold` is still high.
- `load_done` is high for the single cycle the FSM is in DONE.
- Reset mid-load: returns to IDLE the next cycle and outputs take their reset values. No further writes occur, and a partially assembled word is discarded.
- When `reset` and `start_load` are asserted together, `reset` wins.

## Configuration
- `PRGROM_LOADER_CHECKSUM_EN` defined: the CSUM state and XOR accumulator are compiled in. Completion requires a matching trailing byte; a mismatch raises `load_err`.
- Not defined: no CSUM state and no accumulator. DONE follows the last data word directly, and `load_err` is raised only by length overflow.

## Test plan
- Basic load: `start_load`, then 00 02 12 34 56 78 9A BC DE F0 back-to-back (plus checksum 00 when enabled) → writes addr 0 = 0x12345678 and addr 1 = 0x9ABCDEF0, `load_done` pulse, `word_count` = 2, `cpu_hold` low afterwards.
- Zero length: 00 00 → `load_done` with no `mem_we`; `word_count` = 0.
- Overflow: 40 01 with ADDR_WIDTH = 14 → `load_err` = 1, no writes, return to IDLE. A following `start_load` clears `load_err`.
- Checksum (macro on): 00 01 11 22 33 44 then byte 45 → write 0x11223344, then `load_err` = 1 with no `load_done`. Using byte 44 instead → `load_done`.
- Reset mid-load: assert `reset` after 00 02 11 22 → no `mem_we` ever, all outputs 0. Bytes arriving afterwards without `start_load` are ignored.
- Spaced bytes: insert 0–5 idle cycles between bytes, and send stray bytes while in IDLE → results identical to the basic load.
